// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//   Sequencing controller for the 33-cycle radix-2 signed divider in EX.
//   Accepts DIV / MTHI / MTLO operations, launches the external divider, owns
//   the architectural HI/LO registers and stalls the pipeline while a divide
//   is pending. Divide-by-zero is resolved locally without the divider, and
//   results of flushed (cancelled) divides are discarded.
//
// Ports
//   clock, reset         system clock (rising edge), async active-low reset
//   op_valid, op         operation request: 00 DIV, 01 MTHI, 10 MTLO, 11 nop
//   op_a, op_b           dividend / MT source, divisor
//   cancel               pipeline flush, aborts a pending DIV
//   cpu_stall            external pipeline stall (forwarded to the divider)
//   mf_req               EX reads HI/LO this cycle
//   op_ready             high only in IDLE
//   mdu_stall            (op_valid | mf_req) while not ready
//   hi, lo               architectural HI (remainder) / LO (quotient)
//   done, dz             one-cycle completion pulse / divide-by-zero flag
//   div_start            registered one-cycle start pulse to the divider
//   div_dividend/divisor operands latched at acceptance
//   div_cpu_stall        combinational copy of cpu_stall
//   div_q, div_r         divider quotient / remainder
//   div_busy, div_finish divider status
// -----------------------------------------------------------------------------
module div_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        cancel,
   input  logic        cpu_stall,
   input  logic        mf_req,
   output logic        op_ready,
   output logic        mdu_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done,
   output logic        dz,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   output logic        div_cpu_stall,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_busy,
   input  logic        div_finish
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_WRITE = 2'b11
   } state_t;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_MTHI = 2'b01;
   localparam logic [1:0] OP_MTLO = 2'b10;

   state_t      state, state_nxt;
   logic [31:0] hi_nxt, lo_nxt;
   logic [31:0] dividend_nxt, divisor_nxt;
   logic        start_nxt;
   logic        dz_flag, dz_flag_nxt;
   logic        accept;

   // Completion is taken from div_finish alone; busy is not needed here.
   logic        unused_div_busy;
   assign unused_div_busy = div_busy;

   assign op_ready      = (state == S_IDLE);
   // A flush in the same cycle as a request wins: nothing is accepted.
   assign accept        = op_valid & op_ready & ~cancel;
   assign mdu_stall     = (op_valid | mf_req) & ~op_ready;
   assign div_cpu_stall = cpu_stall;
   assign done          = (state == S_WRITE);
   assign dz            = done & dz_flag;

   // Next-state and register-update logic.
   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_nxt    = state;
      hi_nxt       = hi;
      lo_nxt       = lo;
      dividend_nxt = div_dividend;
      divisor_nxt  = div_divisor;
      start_nxt    = 1'b0;
      dz_flag_nxt  = dz_flag;

      case (state)
         S_IDLE: begin
            // A late div_finish from a cancelled divide lands here and is ignored.
            if (accept) begin
               case (op)
                  OP_DIV: begin
                     if (op_b == '0) begin
                        // Divide-by-zero resolved locally; divider untouched.
                        hi_nxt      = op_a;
                        lo_nxt      = '1;
                        dz_flag_nxt = 1'b1;
                        state_nxt   = S_WRITE;
                     end else begin
                        dividend_nxt = op_a;
                        divisor_nxt  = op_b;
                        start_nxt    = 1'b1;
                        dz_flag_nxt  = 1'b0;
                        state_nxt    = S_ISSUE;
                     end
                  end
                  OP_MTHI: hi_nxt = op_a;
                  OP_MTLO: lo_nxt = op_a;
                  default: ;  // reserved encoding: accepted, no effect
               endcase
            end
         end

         // The start pulse is already on the wire this cycle; cpu_stall does
         // not hold it, the divider itself accounts for stalled steps.
         S_ISSUE: state_nxt = cancel ? S_IDLE : S_WAIT;

         S_WAIT: begin
            if (cancel) begin
               state_nxt = S_IDLE;
            end else if (div_finish) begin
               lo_nxt    = div_q;
               hi_nxt    = div_r;
               state_nxt = S_WRITE;
            end
         end

         // HI/LO were written on entry; a cancel here cannot undo that.
         S_WRITE: state_nxt = S_IDLE;

         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         hi           <= '0;
         lo           <= '0;
         div_dividend <= '0;
         div_divisor  <= '0;
         div_start    <= 1'b0;
         dz_flag      <= 1'b0;
      end else begin
         state        <= state_nxt;
         hi           <= hi_nxt;
         lo           <= lo_nxt;
         div_dividend <= dividend_nxt;
         div_divisor  <= divisor_nxt;
         div_start    <= start_nxt;
         dz_flag      <= dz_flag_nxt;
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//   Self-checking bench for div_ctrl. A behavioural divider model answers
//   div_start after 32 non-stalled steps. Expected HI/LO/dz for every DIV that
//   must complete are queued when the DIV is driven and popped by a monitor
//   whenever done is seen; a done with nothing queued is an error.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_MTHI = 2'b01;
   localparam logic [1:0] OP_MTLO = 2'b10;

   logic        clock     = 1'b0;
   logic        reset     = 1'b0;
   logic        op_valid  = 1'b0;
   logic [1:0]  op        = 2'b00;
   logic [31:0] op_a      = '0;
   logic [31:0] op_b      = '0;
   logic        cancel    = 1'b0;
   logic        cpu_stall = 1'b0;
   logic        mf_req    = 1'b0;
   logic        op_ready, mdu_stall, done, dz, div_start, div_cpu_stall;
   logic [31:0] hi, lo, div_dividend, div_divisor;
   logic [31:0] div_q      = '0;
   logic [31:0] div_r      = '0;
   logic        div_busy   = 1'b0;
   logic        div_finish = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   div_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .op_valid     (op_valid),
      .op           (op),
      .op_a         (op_a),
      .op_b         (op_b),
      .cancel       (cancel),
      .cpu_stall    (cpu_stall),
      .mf_req       (mf_req),
      .op_ready     (op_ready),
      .mdu_stall    (mdu_stall),
      .hi           (hi),
      .lo           (lo),
      .done         (done),
      .dz           (dz),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_cpu_stall(div_cpu_stall),
      .div_q        (div_q),
      .div_r        (div_r),
      .div_busy     (div_busy),
      .div_finish   (div_finish)
   );

   always #5 clock = ~clock;

   // Divider model: latches on div_start, then 32 steps on non-stalled edges;
   // div_finish is a one-cycle pulse. Not reset by the controller's reset.
   logic signed [31:0] m_a = '0;
   logic signed [31:0] m_b = 32'sd1;
   int                 m_cnt = 0;

   always @(posedge clock) begin
      div_finish <= 1'b0;
      if (div_start === 1'b1) begin
         m_a      <= div_dividend;
         m_b      <= div_divisor;
         m_cnt    <= 0;
         div_busy <= 1'b1;
      end else if (div_busy && !div_cpu_stall) begin
         if (m_cnt == 31) begin
            div_busy   <= 1'b0;
            div_finish <= 1'b1;
            div_q      <= m_a / m_b;
            div_r      <= m_a % m_b;
         end
         m_cnt <= m_cnt + 1;
      end
   end

   // Scoreboard monitor: every done must match the oldest queued expectation.
   always @(negedge clock) begin
      if (done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done=1 hi=%h lo=%h with nothing expected", hi, lo);
         end else begin
            mon_e = sb.pop_front();
            if (hi !== mon_e.hi || lo !== mon_e.lo || dz !== mon_e.dz) begin
               errors++;
               $display("FAIL div_result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                        hi, lo, dz, mon_e.hi, mon_e.lo, mon_e.dz);
            end
         end
      end
   end

   task automatic expect_result(input logic [31:0] h, input logic [31:0] l, input logic z);
      exp_t e;
      e.hi = h;
      e.lo = l;
      e.dz = z;
      sb.push_back(e);
   endtask

   // Presents one request for exactly one edge (the accept edge E0).
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      op       = o;
      op_a     = a;
      op_b     = b;
      @(posedge clock);
      #1;
      op_valid = 1'b0;
   endtask

   // lat = index k of the cycle Ek..Ek+1 in which done is first seen.
   task automatic wait_done(output int lat, output int starts);
      lat    = 0;
      starts = 0;
      while (lat < 200) begin
         @(negedge clock);
         if (div_start === 1'b1) starts++;
         if (done === 1'b1) break;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({hi, lo, done, dz, div_start, div_dividend, div_divisor, op_ready, mdu_stall} !==
          {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: hi=%h lo=%h done=%b dz=%b start=%b dvd=%h dvs=%h rdy=%b stall=%b",
                  hi, lo, done, dz, div_start, div_dividend, div_divisor, op_ready, mdu_stall);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_div_basic();
      int lat, starts;
      expect_result(32'd2, 32'hFFFF_FFF2, 1'b0);
      issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
      wait_done(lat, starts);
      checks++;
      if (lat !== 34) begin
         errors++;
         $display("FAIL basic_latency: done at cycle %0d, want 34", lat);
      end
      checks++;
      if (starts !== 1) begin
         errors++;
         $display("FAIL basic_start_pulses: got %0d, want 1", starts);
      end
      @(negedge clock);
      checks++;
      if (op_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_back_idle: op_ready=%b done=%b, want 1 0", op_ready, done);
      end
      checks++;
      if (div_dividend !== 32'd100 || div_divisor !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL basic_operands: got %h/%h, want 00000064/fffffff9", div_dividend, div_divisor);
      end
   endtask

   task automatic test_div_stall();
      int  lat;
      logic bad;
      bad = 1'b0;
      expect_result(32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
      issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
      lat = 0;
      while (lat < 200) begin
         @(negedge clock);
         if (done === 1'b1) break;
         if (lat >= 6 && lat <= 9 && (mdu_stall !== 1'b1 || div_cpu_stall !== 1'b1)) bad = 1'b1;
         cpu_stall = (lat >= 5 && lat < 10);
         mf_req    = (lat >= 5 && lat < 10);
         lat++;
      end
      cpu_stall = 1'b0;
      mf_req    = 1'b0;
      checks++;
      if (lat !== 39) begin
         errors++;
         $display("FAIL stall_latency: done at cycle %0d, want 39", lat);
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL stall_mdu_stall: mdu_stall/div_cpu_stall dropped during WAIT, want both 1");
      end
      @(negedge clock);
      mf_req = 1'b1;
      #1;
      checks++;
      if (mdu_stall !== 1'b0) begin
         errors++;
         $display("FAIL idle_mf_req: mdu_stall=%b, want 0", mdu_stall);
      end
      mf_req = 1'b0;
   endtask

   task automatic test_div_zero();
      int lat, starts;
      expect_result(32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
      issue(OP_DIV, 32'h0000_1234, 32'h0);
      wait_done(lat, starts);
      checks++;
      if (lat !== 0 || starts !== 0) begin
         errors++;
         $display("FAIL dz_timing: done at cycle %0d with %0d starts, want 0 and 0", lat, starts);
      end
      checks++;
      if (div_dividend !== 32'hFFFF_FF9C || div_divisor !== 32'd7) begin
         errors++;
         $display("FAIL dz_operands_held: got %h/%h, want ffffff9c/00000007", div_dividend, div_divisor);
      end
      @(negedge clock);
      checks++;
      if (op_ready !== 1'b1 || done !== 1'b0 || dz !== 1'b0 || div_start !== 1'b0) begin
         errors++;
         $display("FAIL dz_after: rdy=%b done=%b dz=%b start=%b, want 1 0 0 0", op_ready, done, dz, div_start);
      end
   endtask

   task automatic test_mt();
      op_valid = 1'b1;
      op       = OP_MTHI;
      op_a     = 32'h0000_AAAA;
      @(posedge clock);
      #1;
      op   = OP_MTLO;
      op_a = 32'h0000_5555;
      @(negedge clock);
      checks++;
      if (hi !== 32'h0000_AAAA || lo !== 32'hFFFF_FFFF || op_ready !== 1'b1) begin
         errors++;
         $display("FAIL mthi: hi=%h lo=%h rdy=%b, want 0000aaaa ffffffff 1", hi, lo, op_ready);
      end
      @(posedge clock);
      #1;
      op_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
         errors++;
         $display("FAIL mtlo: hi=%h lo=%h, want 0000aaaa 00005555", hi, lo);
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_mt_during_div();
      int lat, starts;
      expect_result(32'd2, 32'd14, 1'b0);
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (5) @(negedge clock);
      op_valid = 1'b1;
      op       = OP_MTHI;
      op_a     = 32'h0000_BEEF;
      #1;
      checks++;
      if (op_ready !== 1'b0 || mdu_stall !== 1'b1) begin
         errors++;
         $display("FAIL mt_blocked: rdy=%b mdu_stall=%b, want 0 1", op_ready, mdu_stall);
      end
      wait_done(lat, starts);
      @(negedge clock);
      checks++;
      if (op_ready !== 1'b1 || hi !== 32'd2 || mdu_stall !== 1'b0) begin
         errors++;
         $display("FAIL mt_after_done: rdy=%b hi=%h stall=%b, want 1 00000002 0", op_ready, hi, mdu_stall);
      end
      @(posedge clock);
      #1;
      op_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (hi !== 32'h0000_BEEF || lo !== 32'd14) begin
         errors++;
         $display("FAIL mt_overwrite: hi=%h lo=%h, want 0000beef 0000000e", hi, lo);
      end
   endtask

   task automatic test_cancel();
      int lat, starts, n;
      issue(OP_DIV, 32'd50, 32'd5);
      repeat (10) @(negedge clock);
      cancel = 1'b1;
      @(posedge clock);
      #1;
      cancel = 1'b0;
      @(negedge clock);
      checks++;
      if (op_ready !== 1'b1 || hi !== 32'h0000_BEEF || lo !== 32'd14) begin
         errors++;
         $display("FAIL cancel_idle: rdy=%b hi=%h lo=%h, want 1 0000beef 0000000e", op_ready, hi, lo);
      end
      n = 0;
      while (div_finish !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      checks++;
      if (hi !== 32'h0000_BEEF || lo !== 32'd14 || op_ready !== 1'b1) begin
         errors++;
         $display("FAIL cancel_late_finish: hi=%h lo=%h rdy=%b, want 0000beef 0000000e 1", hi, lo, op_ready);
      end
      expect_result(32'd1, 32'd4, 1'b0);
      issue(OP_DIV, 32'd9, 32'd2);
      wait_done(lat, starts);
      checks++;
      if (lat !== 34 || starts !== 1) begin
         errors++;
         $display("FAIL after_cancel_div: done at cycle %0d with %0d starts, want 34 and 1", lat, starts);
      end
      @(negedge clock);
   endtask

   task automatic test_cancel_wins();
      op_valid = 1'b1;
      op       = OP_DIV;
      op_a     = 32'd8;
      op_b     = 32'd0;
      cancel   = 1'b1;
      @(posedge clock);
      #1;
      op_valid = 1'b0;
      cancel   = 1'b0;
      @(negedge clock);
      checks++;
      if (op_ready !== 1'b1 || div_start !== 1'b0 || hi !== 32'd1 || lo !== 32'd4 || div_dividend !== 32'd9) begin
         errors++;
         $display("FAIL cancel_wins: rdy=%b start=%b hi=%h lo=%h dvd=%h, want 1 0 00000001 00000004 00000009",
                  op_ready, div_start, hi, lo, div_dividend);
      end
   endtask

   task automatic test_reset_mid_wait();
      int n;
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (10) @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0 || op_ready !== 1'b1 || done !== 1'b0 || div_dividend !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_wait: hi=%h lo=%h rdy=%b done=%b dvd=%h, want 0 0 1 0 0",
                  hi, lo, op_ready, done, div_dividend);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      n = 0;
      while (div_finish !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      repeat (2) @(negedge clock);
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0 || op_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_late_finish: hi=%h lo=%h rdy=%b, want 0 0 1", hi, lo, op_ready);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_div_basic();
      test_div_stall();
      test_div_zero();
      test_mt();
      test_mt_during_div();
      test_cancel();
      test_cancel_wins();
      test_reset_mid_wait();
      repeat (3) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected results never completed, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
